// File: rtl/owl_pkg.sv
// ---------------------------------------------------------------------------
// owl_pkg
// Shared definitions for the one-wire link (OWL) slave controller:
//   - owlState_t : controller FSM state encoding
//   - ST_OK / ST_NUM0 : response status codes
//   - CRC_INIT / CRC_POLY : CRC-16/MODBUS constants
//   - crc16Step() : one byte-wide CRC-16/MODBUS update step
// ---------------------------------------------------------------------------
package owl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RX_HDR,
        RX_NUM,
        RX_DAT,
        RX_C1,
        RX_C0,
        CHK,
        TURN,
        TX_STAT,
        RD,
        TX_DAT,
        TX_C1,
        TX_C0
    } owlState_t;

    localparam logic [7:0]  ST_OK    = 8'h00;
    localparam logic [7:0]  ST_NUM0  = 8'h01;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    // Reflected CRC-16: the whole byte is folded into the low half first,
    // then eight LSB-first shift/xor steps are unrolled.
    function automatic logic [15:0] crc16Step(input logic [15:0] crcIn,
                                              input logic [7:0]  din);
        logic [15:0] c;
        c = crcIn ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/owl_crc16.sv
// ---------------------------------------------------------------------------
// owl_crc16
// Byte-wise CRC-16/MODBUS accumulator, one byte per clock.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset (register -> CRC_INIT)
//   i_clr    : reload the register to CRC_INIT (has priority over i_calcu)
//   i_calcu  : fold i_din into the running CRC this cycle
//   i_din    : data byte
//   o_dout   : current CRC register value
// ---------------------------------------------------------------------------
module owl_crc16
    import owl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_calcu,
    input  logic [7:0]  i_din,
    output logic [15:0] o_dout
);

    logic [15:0] r_crc;

    // CRC register: clear wins over accumulate so the controller can reload
    // in the same cycle it stops feeding bytes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_calcu) begin
            r_crc <= crc16Step(r_crc, i_din);
        end
    end

    assign o_dout = r_crc;

endmodule

// File: rtl/owl_sctrl.sv
// ---------------------------------------------------------------------------
// owl_sctrl
// Slave-side controller for the one-wire link. Receives a request frame
// {cmd,addr} / num / [data when cmd=1] / crcLo / crcHi from the byte-level
// transceiver, checks the CRC, commits writes to a 128-byte register bus,
// and returns status / [num read bytes when cmd=0] / crcLo / crcHi.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   o_owl_wctrl/o_owl_wdata : one-cycle load strobe and byte for the transmitter
//   i_owl_wflag             : transmitter busy
//   o_owl_rctrl             : receiver enable
//   i_owl_rdata/i_owl_rflag : received byte and its one-cycle valid pulse
//   i_owl_rxsof/i_owl_rxeof : start / end of frame pulses
//   o_reg_addr/o_reg_wdata  : register bus address and write data
//   o_reg_we/o_reg_re       : one-cycle write / read strobes
//   i_reg_rdata             : read data, valid the cycle after o_reg_re
//   o_frm_ok/o_crc_err/o_to_err : event pulses
// ---------------------------------------------------------------------------
module owl_sctrl
    import owl_pkg::*;
#(
    parameter int                   CNT_WIDTH   = 12,
    parameter logic [CNT_WIDTH-1:0] TO_CYCLES   = 12'hFA0,
    parameter logic [CNT_WIDTH-1:0] TURN_CYCLES = 12'h0C8
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_owl_wctrl,
    output logic [7:0] o_owl_wdata,
    input  logic       i_owl_wflag,
    output logic       o_owl_rctrl,
    input  logic [7:0] i_owl_rdata,
    input  logic       i_owl_rflag,
    input  logic       i_owl_rxsof,
    input  logic       i_owl_rxeof,
    output logic [6:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_frm_ok,
    output logic       o_crc_err,
    output logic       o_to_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TURN_LAST = TURN_CYCLES - CNT_ONE;

    owlState_t r_state;
    owlState_t w_next;

    logic                 r_cmd;
    logic [6:0]           r_addr;
    logic [7:0]           r_num;
    logic [7:0]           r_data;
    logic [15:0]          r_crcRx;
    logic [7:0]           r_byteCnt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sent;

    logic                 w_crcClr;
    logic                 w_crcCalc;
    logic [7:0]           w_crcDin;
    logic [15:0]          w_crc;
    logic                 w_timeout;
    logic [7:0]           w_status;
    logic [7:0]           w_cntInc;
    logic                 w_unusedRxeof;

    // Framing is governed purely by the byte count, so end-of-frame is not needed.
    assign w_unusedRxeof = i_owl_rxeof;

    assign w_timeout = (r_cnt == TO_CYCLES);
    assign w_status  = (!r_cmd && (r_num == 8'h00)) ? ST_NUM0 : ST_OK;
    assign w_cntInc  = r_byteCnt + 8'd1;

    owl_crc16 u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_crcClr),
        .i_calcu (w_crcCalc),
        .i_din   (w_crcDin),
        .o_dout  (w_crc)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode. Every TX state uses the same two-phase
    // handshake: load the byte once the transmitter is idle (r_sent=0), then
    // leave once it has drained that byte (r_sent=1 and busy low). The CRC is
    // cleared continuously in IDLE and reloaded in CHK for the response.
    always_comb begin
        w_next      = r_state;
        o_owl_rctrl = 1'b0;
        o_owl_wctrl = 1'b0;
        o_owl_wdata = 8'h00;
        o_reg_addr  = 7'h00;
        o_reg_wdata = 8'h00;
        o_reg_we    = 1'b0;
        o_reg_re    = 1'b0;
        o_frm_ok    = 1'b0;
        o_crc_err   = 1'b0;
        o_to_err    = 1'b0;
        w_crcClr    = 1'b0;
        w_crcCalc   = 1'b0;
        w_crcDin    = 8'h00;

        case (r_state)
            IDLE: begin
                w_crcClr = 1'b1;
                if (i_owl_rxsof) w_next = RX_HDR;
            end
            RX_HDR, RX_NUM, RX_DAT, RX_C1, RX_C0: begin
                o_owl_rctrl = 1'b1;
                if (i_owl_rflag) begin
                    w_crcDin = i_owl_rdata;
                    case (r_state)
                        RX_HDR: begin
                            w_crcCalc = 1'b1;
                            w_next    = RX_NUM;
                        end
                        RX_NUM: begin
                            w_crcCalc = 1'b1;
                            w_next    = r_cmd ? RX_DAT : RX_C1;
                        end
                        RX_DAT: begin
                            w_crcCalc = 1'b1;
                            w_next    = RX_C1;
                        end
                        RX_C1:   w_next = RX_C0;
                        default: w_next = CHK;
                    endcase
                end else if (w_timeout) begin
                    o_to_err = 1'b1;
                    w_next   = IDLE;
                end
            end
            CHK: begin
                if (r_crcRx == w_crc) begin
                    o_frm_ok = 1'b1;
                    w_crcClr = 1'b1;
                    w_next   = TURN;
                    if (r_cmd) begin
                        o_reg_we    = 1'b1;
                        o_reg_addr  = r_addr;
                        o_reg_wdata = r_data;
                    end
                end else begin
                    o_crc_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            TURN: begin
                if (r_cnt == TURN_LAST) w_next = TX_STAT;
            end
            TX_STAT: begin
                if (!i_owl_wflag) begin
                    if (!r_sent) begin
                        o_owl_wctrl = 1'b1;
                        o_owl_wdata = w_status;
                        w_crcCalc   = 1'b1;
                        w_crcDin    = w_status;
                    end else begin
                        w_next = (!r_cmd && (r_num != 8'h00)) ? RD : TX_C1;
                    end
                end
            end
            RD: begin
                o_reg_re   = 1'b1;
                o_reg_addr = r_addr + r_byteCnt[6:0];
                w_next     = TX_DAT;
            end
            TX_DAT: begin
                if (!i_owl_wflag) begin
                    if (!r_sent) begin
                        o_owl_wctrl = 1'b1;
                        o_owl_wdata = i_reg_rdata;
                        w_crcCalc   = 1'b1;
                        w_crcDin    = i_reg_rdata;
                    end else begin
                        w_next = (w_cntInc == r_num) ? TX_C1 : RD;
                    end
                end
            end
            TX_C1: begin
                if (!i_owl_wflag) begin
                    if (!r_sent) begin
                        o_owl_wctrl = 1'b1;
                        o_owl_wdata = w_crc[7:0];
                    end else begin
                        w_next = TX_C0;
                    end
                end
            end
            TX_C0: begin
                if (!i_owl_wflag) begin
                    if (!r_sent) begin
                        o_owl_wctrl = 1'b1;
                        o_owl_wdata = w_crc[15:8];
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latched request fields, per-state cycle counter, read byte
    // counter and the "byte already loaded" flag for the TX handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd     <= 1'b0;
            r_addr    <= 7'h00;
            r_num     <= 8'h00;
            r_data    <= 8'h00;
            r_crcRx   <= 16'h0000;
            r_byteCnt <= 8'h00;
            r_cnt     <= '0;
            r_sent    <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : (r_cnt + CNT_ONE);

            if (w_next != r_state) begin
                r_sent <= 1'b0;
            end else if (o_owl_wctrl) begin
                r_sent <= 1'b1;
            end

            if (i_owl_rflag) begin
                case (r_state)
                    RX_HDR: begin
                        r_cmd  <= i_owl_rdata[7];
                        r_addr <= i_owl_rdata[6:0];
                    end
                    RX_NUM:  r_num          <= i_owl_rdata;
                    RX_DAT:  r_data         <= i_owl_rdata;
                    RX_C1:   r_crcRx[7:0]   <= i_owl_rdata;
                    RX_C0:   r_crcRx[15:8]  <= i_owl_rdata;
                    default: ;
                endcase
            end

            if (r_state == CHK) begin
                r_byteCnt <= 8'h00;
            end else if ((r_state == TX_DAT) && (w_next != TX_DAT)) begin
                r_byteCnt <= w_cntInc;
            end
        end
    end

endmodule

// File: tb/tb_owl_sctrl.sv
// ---------------------------------------------------------------------------
// tb_owl_sctrl
// Self-checking bench for owl_sctrl: directed frames from the test plan plus
// a batch of randomized read/write frames, compared against a frame-level
// reference model (expected register traffic and response byte list).
// ---------------------------------------------------------------------------
module tb_owl_sctrl;
    import owl_pkg::*;

    localparam int TO_CYC   = 4000;
    localparam int TURN_CYC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       owlWctrl, owlRctrl, owlWflag;
    logic [7:0] owlWdata;
    logic [7:0] owlRdata = 8'h00;
    logic       owlRflag = 1'b0, owlRxsof = 1'b0, owlRxeof = 1'b0;
    logic [6:0] regAddr;
    logic [7:0] regWdata;
    logic       regWe, regRe;
    logic [7:0] regRdata = 8'h00;
    logic       frmOk, crcErr, toErr;

    logic        crcClr = 1'b0, crcCalc = 1'b0;
    logic [7:0]  crcDin = 8'h00;
    logic [15:0] crcDout;

    int checkCount = 0;
    int failCount  = 0;

    // Peripheral memory (written by the DUT) and the model's own copy.
    logic [7:0] mem      [128];
    logic [7:0] modelMem [128];

    logic [7:0]  txQ[$];
    logic [6:0]  rdQ[$];
    logic [14:0] wrQ[$];
    logic [7:0]  reqQ[$];
    int busyCnt = 0;
    int frmOkCnt = 0, crcErrCnt = 0, toErrCnt = 0, wrWhileBusy = 0;

    always #5 clk = ~clk;

    assign owlWflag = (busyCnt != 0);

    owl_sctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_owl_wctrl (owlWctrl),
        .o_owl_wdata (owlWdata),
        .i_owl_wflag (owlWflag),
        .o_owl_rctrl (owlRctrl),
        .i_owl_rdata (owlRdata),
        .i_owl_rflag (owlRflag),
        .i_owl_rxsof (owlRxsof),
        .i_owl_rxeof (owlRxeof),
        .o_reg_addr  (regAddr),
        .o_reg_wdata (regWdata),
        .o_reg_we    (regWe),
        .o_reg_re    (regRe),
        .i_reg_rdata (regRdata),
        .o_frm_ok    (frmOk),
        .o_crc_err   (crcErr),
        .o_to_err    (toErr)
    );

    owl_crc16 u_crc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (crcClr),
        .i_calcu (crcCalc),
        .i_din   (crcDin),
        .o_dout  (crcDout)
    );

    // Transmitter, register peripheral and pulse monitors, all sampled on
    // the falling edge so the DUT's combinational outputs have settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt = 0;
        end else begin
            if (owlWctrl) begin
                if (busyCnt != 0) wrWhileBusy++;
                txQ.push_back(owlWdata);
                busyCnt = $urandom_range(1, 4);
            end else if (busyCnt != 0) begin
                busyCnt--;
            end
            if (regWe) begin
                wrQ.push_back({regAddr, regWdata});
                mem[regAddr] = regWdata;
            end
            if (regRe) begin
                rdQ.push_back(regAddr);
                regRdata = mem[regAddr];
            end
            if (frmOk)  frmOkCnt++;
            if (crcErr) crcErrCnt++;
            if (toErr)  toErrCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial MODBUS CRC: one input bit at a time against the LSB.
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        owlRdata = b;
        owlRflag = 1'b1;
        owlRxeof = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        owlRflag = 1'b0;
        owlRxeof = 1'b0;
        owlRdata = 8'($urandom);
    endtask

    // Drive the request bytes held in reqQ as one frame with random gaps.
    task automatic applyStimulus();
        @(negedge clk);
        owlRxsof = 1'b1;
        @(negedge clk);
        owlRxsof = 1'b0;
        foreach (reqQ[i]) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sendByte(reqQ[i]);
        end
    endtask

    task automatic buildRequest(input logic cmd, input logic [6:0] addr,
                                input logic [7:0] num, input logic [7:0] data,
                                input bit bad);
        logic [15:0] c;
        reqQ.delete();
        reqQ.push_back({cmd, addr});
        reqQ.push_back(num);
        if (cmd) reqQ.push_back(data);
        c = 16'hFFFF;
        foreach (reqQ[i]) c = crcByte(c, reqQ[i]);
        reqQ.push_back(c[7:0]);
        reqQ.push_back(bad ? (c[15:8] ^ 8'hFF) : c[15:8]);
    endtask

    task automatic runFrame(input logic cmd, input logic [6:0] addr,
                            input logic [7:0] num, input logic [7:0] data,
                            input bit bad);
        logic [7:0]  resp[$];
        logic [15:0] c;
        logic [6:0]  a;
        int ok0, err0, n;
        txQ.delete(); rdQ.delete(); wrQ.delete();
        ok0  = frmOkCnt;
        err0 = crcErrCnt;
        buildRequest(cmd, addr, num, data, bad);
        applyStimulus();
        if (bad) begin
            repeat (2 * TURN_CYC) @(posedge clk);
            checkOutput("badCrcErr",   32'(crcErrCnt - err0), 32'd1);
            checkOutput("badFrmOk",    32'(frmOkCnt - ok0),   32'd0);
            checkOutput("badNoTx",     32'(txQ.size()),       32'd0);
            checkOutput("badNoWrite",  32'(wrQ.size()),       32'd0);
        end else begin
            // Stray receive activity during the turnaround must be ignored.
            if ($urandom_range(0, 1) == 1) begin
                repeat (20) @(negedge clk);
                owlRxsof = 1'b1;
                sendByte(8'($urandom));
                owlRxsof = 1'b0;
            end
            resp.push_back((!cmd && num == 8'h00) ? 8'h01 : 8'h00);
            if (!cmd) begin
                a = addr;
                for (int i = 0; i < int'(num); i++) begin
                    resp.push_back(modelMem[a]);
                    a = a + 7'd1;
                end
            end
            c = 16'hFFFF;
            foreach (resp[i]) c = crcByte(c, resp[i]);
            resp.push_back(c[7:0]);
            resp.push_back(c[15:8]);
            if (cmd) modelMem[addr] = data;

            n = 0;
            while (txQ.size() < resp.size() && n < 6000) begin
                @(posedge clk);
                n++;
            end
            repeat (12) @(posedge clk);
            checkOutput("txLen", 32'(txQ.size()), 32'(resp.size()));
            for (int i = 0; i < resp.size(); i++) begin
                if (i < txQ.size()) checkOutput($sformatf("txByte%0d", i), 32'(txQ[i]), 32'(resp[i]));
            end
            checkOutput("rdCount", 32'(rdQ.size()), cmd ? 32'd0 : 32'(num));
            a = addr;
            for (int i = 0; i < rdQ.size(); i++) begin
                checkOutput($sformatf("rdAddr%0d", i), 32'(rdQ[i]), 32'(a));
                a = a + 7'd1;
            end
            checkOutput("weCount", 32'(wrQ.size()), 32'(cmd));
            if (cmd && wrQ.size() > 0) checkOutput("weAddrData", 32'(wrQ[0]), 32'({addr, data}));
            checkOutput("frmOk",  32'(frmOkCnt - ok0),   32'd1);
            checkOutput("crcErr", 32'(crcErrCnt - err0), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] ascii [9];
        int n, to0;
        for (int i = 0; i < 128; i++) begin
            mem[i]      = 8'($urandom);
            modelMem[i] = mem[i];
        end
        mem[7'h7E] = 8'h11; modelMem[7'h7E] = 8'h11;
        mem[7'h7F] = 8'h22; modelMem[7'h7F] = 8'h22;
        mem[7'h00] = 8'h33; modelMem[7'h00] = 8'h33;

        repeat (3) @(negedge clk);
        checkOutput("rstOutputs",
                    32'({owlWctrl, owlRctrl, regWe, regRe, frmOk, crcErr, toErr,
                         owlWdata, regAddr, regWdata}), 32'd0);
        checkOutput("rstCrc", 32'(crcDout), 32'hFFFF);
        rst_n = 1'b1;

        // CRC sub-module on the standard check string.
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge clk);
        crcClr = 1'b1;
        @(negedge clk);
        crcClr  = 1'b0;
        crcCalc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            crcDin = ascii[i];
            @(negedge clk);
        end
        crcCalc = 1'b0;
        checkOutput("crcUnit", 32'(crcDout), 32'h4B37);

        // Directed frames.
        runFrame(1'b1, 7'h05, 8'h01, 8'h3C, 1'b0);
        runFrame(1'b0, 7'h7E, 8'h03, 8'h00, 1'b0);
        runFrame(1'b1, 7'h22, 8'h01, 8'h5A, 1'b1);
        runFrame(1'b0, 7'h40, 8'h00, 8'h00, 1'b0);

        // Inter-byte timeout after the header only.
        txQ.delete();
        to0 = toErrCnt;
        reqQ.delete();
        reqQ.push_back(8'h12);
        applyStimulus();
        repeat (TO_CYC + 20) @(posedge clk);
        checkOutput("toErr",   32'(toErrCnt - to0), 32'd1);
        checkOutput("toNoTx",  32'(txQ.size()),     32'd0);
        checkOutput("toIdle",  32'(owlRctrl),       32'd0);
        runFrame(1'b0, 7'h05, 8'h02, 8'h00, 1'b0);

        // Full-length read wrapping the address space.
        runFrame(1'b0, 7'($urandom), 8'hFF, 8'h00, 1'b0);

        // Reset while the controller is sending read data.
        rdQ.delete();
        buildRequest(1'b0, 7'h10, 8'h0A, 8'h00, 1'b0);
        applyStimulus();
        n = 0;
        while (rdQ.size() < 3 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reachTxDat", 32'(rdQ.size() >= 3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstMidWctrl", 32'(owlWctrl), 32'd0);
        checkOutput("rstMidRe",    32'(regRe),    32'd0);
        checkOutput("rstMidState", 32'(u_dut.r_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        runFrame(1'b0, 7'h7D, 8'h04, 8'h00, 1'b0);

        // Randomized frames.
        for (int k = 0; k < 25; k++) begin
            logic       rc;
            logic [6:0] ra;
            logic [7:0] rn;
            rc = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 2) == 0) ? 7'(7'h7C + 7'($urandom_range(0, 3))) : 7'($urandom);
            rn = rc ? 8'($urandom) : 8'($urandom_range(0, 6));
            runFrame(rc, ra, rn, 8'($urandom), $urandom_range(0, 4) == 0);
        end

        checkOutput("wctrlWhileBusy", 32'(wrWhileBusy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
